// File: rtl/count_mod_ud_if.sv
// rtl/count_mod_ud_if.sv - control/status bundle for the modulo-N up/down counter
// master drives the step/load controls, slave is the counter itself.
interface count_mod_ud_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up;
  logic             clr_sync;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output enable, up, clr_sync, load, load_val,
    input  count, tc, wrap, done
  );

  modport slave (
    input  enable, up, clr_sync, load, load_val,
    output count, tc, wrap, done
  );
endinterface

// File: rtl/count_mod_ud.sv
// rtl/count_mod_ud.sv - modulo-N up/down counter with load, sync clear and optional one-shot
// Optional saturating mode (free-running build only) enabled by macro COUNT_MOD_UD_SAT_EN.
module count_mod_ud #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int ONESHOT = 0
) (
  input  logic           clock,
  input  logic           ctrl,
  count_mod_ud_if.slave  bus
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("count_mod_ud: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM_HI  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
  localparam bit               ONE_SHOT = (ONESHOT != 0);
`ifdef COUNT_MOD_UD_SAT_EN
  localparam bit               SAT      = !ONE_SHOT;
`else
  localparam bit               SAT      = 1'b0;
`endif

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             tc;

  // Terminal depends only on the current count and direction, so a cascade
  // stage can gate its own enable with enable & tc.
  assign tc = bus.up ? (count_q == TERM_HI) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    done_d  = done_q;
    wrap_d  = 1'b0;
    if (bus.clr_sync) begin
      count_d = '0;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = ({1'b0, bus.load_val} >= MOD_EXT) ? TERM_HI : bus.load_val;
      state_d = ST_RUN;
      done_d  = 1'b0;
    end else if (bus.enable && state_q == ST_RUN) begin
      if (tc && ONE_SHOT) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
        wrap_d  = 1'b1;
      end else if (tc && SAT) begin
        count_d = count_q;
      end else begin
        wrap_d = tc;
        // Compare-then-select keeps non-power-of-2 moduli correct.
        if (bus.up) begin
          count_d = (count_q == TERM_HI) ? '0 : count_q + WIDTH'(1);
        end else begin
          count_d = (count_q == '0) ? TERM_HI : count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl) begin
    if (ctrl) begin
      state_q <= ST_RUN;
      count_q <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc;
  assign bus.wrap  = wrap_q;
  assign bus.done  = ONE_SHOT ? done_q : 1'b0;

endmodule

// File: tb/tb_count_mod_ud.sv
// tb/tb_count_mod_ud.sv - scoreboard bench for count_mod_ud, free-running and one-shot instances
// Both instances (WIDTH=4, MODULUS=10) receive identical stimulus.
module tb_count_mod_ud;

  localparam int W = 4;
  localparam int M = 10;

  logic clock = 1'b0;
  logic ctrl  = 1'b0;
  always #5 clock = ~clock;

  count_mod_ud_if #(.WIDTH(W)) if0 ();
  count_mod_ud_if #(.WIDTH(W)) if1 ();

  count_mod_ud #(.WIDTH(W), .MODULUS(M), .ONESHOT(0)) dut_free (
    .clock (clock),
    .ctrl  (ctrl),
    .bus   (if0.slave)
  );

  count_mod_ud #(.WIDTH(W), .MODULUS(M), .ONESHOT(1)) dut_once (
    .clock (clock),
    .ctrl  (ctrl),
    .bus   (if1.slave)
  );

  typedef struct {
    int c0; bit tc0; bit w0;
    int c1; bit tc1; bit w1; bit d1;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: free-running counter and one-shot counter.
  int m_c0 = 0;
  int m_c1 = 0, m_d1 = 0;
  bit m_w0 = 0, m_w1 = 0;
  bit cur_up = 0;

`ifdef COUNT_MOD_UD_SAT_EN
  localparam bit SAT0 = 1'b1;
`else
  localparam bit SAT0 = 1'b0;
`endif

  function automatic bit at_term(int c, bit u);
    return u ? (c == M - 1) : (c == 0);
  endfunction

  function automatic exp_t snapshot();
    exp_t e;
    e.c0 = m_c0; e.tc0 = at_term(m_c0, cur_up); e.w0 = m_w0;
    e.c1 = m_c1; e.tc1 = at_term(m_c1, cur_up); e.w1 = m_w1; e.d1 = m_d1[0];
    return e;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, want);
    end
  endtask

  // One clock worth of stimulus; called at a falling edge, returns at the next one.
  task automatic drive(bit clr, bit ld, int lv, bit en, bit u);
    int nxt;
    if0.clr_sync = clr; if0.load = ld; if0.load_val = W'(lv); if0.enable = en; if0.up = u;
    if1.clr_sync = clr; if1.load = ld; if1.load_val = W'(lv); if1.enable = en; if1.up = u;
    cur_up = u;
    nxt = u ? (m_c0 + 1) % M : (m_c0 + M - 1) % M;
    if (clr) begin
      m_c0 = 0; m_w0 = 0; m_c1 = 0; m_w1 = 0; m_d1 = 0;
    end else if (ld) begin
      m_c0 = (lv >= M) ? M - 1 : lv; m_w0 = 0;
      m_c1 = m_c0; m_w1 = 0; m_d1 = 0;
    end else begin
      if (en && SAT0 && at_term(m_c0, u)) m_w0 = 0;
      else if (en) begin m_w0 = at_term(m_c0, u); m_c0 = nxt; end
      else m_w0 = 0;
      if (en && m_d1 == 0 && at_term(m_c1, u)) begin m_d1 = 1; m_w1 = 1; end
      else if (en && m_d1 == 0) begin
        m_w1 = 0; m_c1 = u ? (m_c1 + 1) % M : (m_c1 + M - 1) % M;
      end else m_w1 = 0;
    end
    exp_q.push_back(snapshot());
    @(negedge clock);
  endtask

  // Asynchronous reset raised mid-cycle, held across one rising edge.
  task automatic pulse_reset();
    #2;
    m_c0 = 0; m_w0 = 0; m_c1 = 0; m_w1 = 0; m_d1 = 0;
    exp_q.push_back(snapshot());
    exp_q.push_back(snapshot());
    ctrl = 1'b1;
    @(negedge clock);
    ctrl = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock or posedge ctrl);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("free_count", 8'(if0.count), 8'(e.c0));
        chk("free_tc",    8'(if0.tc),    8'(e.tc0));
        chk("free_wrap",  8'(if0.wrap),  8'(e.w0));
        chk("free_done",  8'(if0.done),  8'd0);
        chk("once_count", 8'(if1.count), 8'(e.c1));
        chk("once_tc",    8'(if1.tc),    8'(e.tc1));
        chk("once_wrap",  8'(if1.wrap),  8'(e.w1));
        chk("once_done",  8'(if1.done),  8'(e.d1));
      end
    end
  end

  initial begin : stimulus
    if0.enable = 0; if0.up = 0; if0.clr_sync = 0; if0.load = 0; if0.load_val = '0;
    if1.enable = 0; if1.up = 0; if1.clr_sync = 0; if1.load = 0; if1.load_val = '0;
    @(negedge clock);
    pulse_reset();
    // Up count through the terminal and beyond; one-shot instance stops at 9.
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1);
    // Load 3 and count down across zero.
    drive(0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
    // Out-of-range load clamps, simultaneous enable ignored, then step up.
    drive(0, 1, 12, 1, 1);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    // Long enable run, then direction change while one-shot sits in DONE.
    drive(0, 1, 0, 0, 1);
    for (int i = 0; i < 15; i++) drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    drive(0, 1, 4, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1);
    // Clear beats load; then async reset mid-count.
    drive(0, 1, 6, 0, 1);
    drive(1, 1, 5, 1, 1);
    drive(0, 1, 7, 0, 1);
    drive(0, 0, 0, 0, 1);
    pulse_reset();
    // Randomised phase, direction toggling freely.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) pulse_reset();
      else drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0);
    end
    drive(0, 0, 0, 0, 1);
    @(negedge clock);
    chk("queue_drain", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
